relprime_controller: RTL and testbench

RELPRIME_CONTROLLER -- requirements
Module: relprime_controller

---
 rtl/relprime_pkg.sv | 19 +
 rtl/relprime_gcd_unit.sv | 49 ++++
 rtl/relprime_controller.sv | 123 ++++++++++++
 tb/tb_relprime_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/relprime_pkg.sv
// relprime_pkg
//   Shared definitions for the smallest-coprime search controller:
//   the FSM state type, the default operand width and the first
//   candidate tried for every operand.
package relprime_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned M_START   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_CMP,
    ST_SUB,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage : relprime_pkg

// File: rtl/relprime_gcd_unit.sv
// relprime_gcd_unit
//   Subtractive-Euclid step datapath. Holds the a/b pair, loads a fresh
//   pair on load, performs one subtract step on step, and reports the
//   equality / equal-to-one flags the controller branches on.
//
// Ports
//   CLK, RST_N : clock, asynchronous active-low reset (clears a and b)
//   load       : a <= a_in, b <= b_in
//   step       : larger of a/b reduced by the smaller
//   a_in, b_in : values loaded on load
//   a, b       : current register contents
//   a_eq_b     : a == b
//   a_is_one   : a == 1
module relprime_gcd_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             a_eq_b,
  output logic             a_is_one
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a <= '0;
      b <= '0;
    end else if (load) begin
      a <= a_in;
      b <= b_in;
    end else if (step) begin
      // step is only issued while a != b, so the smaller operand is
      // always strictly less than the larger and no underflow occurs.
      if (a > b) a <= a - b;
      else       b <= b - a;
    end
  end

  always_comb begin
    a_eq_b   = (a == b);
    a_is_one = (a == WIDTH'(1));
  end

endmodule : relprime_gcd_unit

// File: rtl/relprime_controller.sv
// relprime_controller
//   Finds the smallest m >= 2 with gcd(n, m) == 1 by walking candidates
//   upward and running a subtractive GCD for each one.
//
// Ports
//   CLK, RST_N : clock, asynchronous active-low reset
//   start      : request pulse, honoured only while idle
//   n          : operand, captured when start is accepted
//   busy       : high from the cycle after accept through the done cycle
//   done       : one-cycle completion pulse
//   error      : valid with done; set when no result exists (n == 0 or
//                candidate space exhausted)
//   result     : smallest coprime m (0 on error), held until next done
module relprime_controller
  import relprime_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  state_t           state;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] m;

  logic             gcd_load;
  logic             gcd_step;
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic             gcd_eq;
  logic             gcd_one;

  always_comb begin
    gcd_load = (state == ST_INIT);
    gcd_step = (state == ST_SUB);
  end

  relprime_gcd_unit #(
    .WIDTH (WIDTH)
  ) u_gcd (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (gcd_load),
    .step     (gcd_step),
    .a_in     (n_r),
    .b_in     (m),
    .a        (gcd_a),
    .b        (gcd_b),
    .a_eq_b   (gcd_eq),
    .a_is_one (gcd_one)
  );

  // done/result/error are loaded on the edge that enters ST_DONE, so the
  // pulse and its data are visible together during the DONE cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      n_r    <= '0;
      m      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            n_r  <= n;
            m    <= WIDTH'(M_START);
            busy <= 1'b1;
            if (n == '0) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              error  <= 1'b1;
              result <= '0;
            end else begin
              state <= ST_INIT;
            end
          end
        end
        ST_INIT: state <= ST_CMP;
        ST_CMP: begin
          if (!gcd_eq) begin
            state <= ST_SUB;
          end else if (gcd_one) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            error  <= 1'b0;
            result <= m;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_SUB: state <= ST_CMP;
        ST_NEXT: begin
          if (m == '1) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            error  <= 1'b1;
            result <= '0;
          end else begin
            m     <= m + WIDTH'(1);
            state <= ST_INIT;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : relprime_controller

// File: tb/tb_relprime_controller.sv
// tb_relprime_controller
//   Self-checking bench for relprime_controller: directed cases, busy /
//   done-cycle start rejection, mid-run reset, and random operands
//   compared against an arithmetic smallest-coprime model.
module tb_relprime_controller;
  import relprime_pkg::*;

  localparam int unsigned W     = 16;
  localparam int          LIMIT = 400000;

  logic         CLK;
  logic         RST_N;
  logic         start;
  logic [W-1:0] n;
  logic         busy;
  logic         done;
  logic         error;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  relprime_controller #(
    .WIDTH (W)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .start  (start),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .result (result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned gcd_ref(input int unsigned x, input int unsigned y);
    int unsigned p = x;
    int unsigned q = y;
    while (q != 0) begin
      int unsigned t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Smallest m >= 2 coprime to nv; 0 when none exists in W-bit range.
  function automatic int unsigned coprime_ref(input int unsigned nv);
    if (nv == 0) return 0;
    for (int unsigned mm = 2; mm < (1 << W); mm++)
      if (gcd_ref(nv, mm) == 1) return mm;
    return 0;
  endfunction

  task automatic wait_idle();
    int k = 0;
    @(negedge CLK);
    while ((busy || done) && k < LIMIT) begin
      @(negedge CLK);
      k++;
    end
  endtask

  // Issue one start and return the first done's data and its latency.
  task automatic run_op(input logic [W-1:0] nv, output logic [W-1:0] res,
                        output logic err, output int cyc, output int dones);
    wait_idle();
    start = 1'b1;
    n     = nv;
    @(posedge CLK);
    #1;
    start = 1'b0;
    n     = W'($urandom);
    cyc   = 0;
    dones = 0;
    res   = '0;
    err   = 1'b0;
    while (cyc < LIMIT) begin
      @(negedge CLK);
      cyc++;
      if (done) begin
        dones++;
        res = result;
        err = error;
        break;
      end
    end
  endtask

  task automatic do_case(input string tag, input logic [W-1:0] nv, input bit full);
    logic [W-1:0] res;
    logic         err;
    int           cyc;
    int           dones;
    int unsigned  exp_m;
    exp_m = coprime_ref(nv);
    run_op(nv, res, err, cyc, dones);
    check({tag, "_done"},   dones, 1);
    check({tag, "_result"}, res,   exp_m);
    check({tag, "_error"},  err,   (nv == 0));
    if (nv == 0) check({tag, "_lat"}, (cyc <= 2), 1);
    if (full) begin
      @(negedge CLK);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_single"},     done, 0);
      repeat (3) @(negedge CLK);
      check({tag, "_hold_res"}, result, exp_m);
      check({tag, "_hold_err"}, error,  (nv == 0));
    end
  endtask

  initial begin
    logic [W-1:0] res;
    logic         err;
    int           cyc;
    int           dones;
    int           k;

    start = 1'b0;
    n     = '0;
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_error",  error,  0);
    check("rst_result", result, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    do_case("n30030", 16'd30030, 1'b1);
    do_case("n1",     16'd1,     1'b1);
    do_case("n2",     16'd2,     1'b1);
    do_case("n9",     16'd9,     1'b1);
    do_case("n0",     16'd0,     1'b1);
    do_case("n65535", 16'd65535, 1'b1);

    // start during the DONE cycle must be dropped, not queued
    run_op(16'd4, res, err, cyc, dones);
    check("dc_result", res, 3);
    start = 1'b1;
    n     = 16'd1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    @(negedge CLK);
    check("dc_ignored", busy, 0);
    repeat (4) @(negedge CLK);
    check("dc_no_done", done, 0);

    // second start while busy is ignored; exactly one done pulse
    wait_idle();
    start = 1'b1;
    n     = 16'd30030;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    start = 1'b1;
    n     = 16'd5;
    @(posedge CLK);
    #1;
    start = 1'b0;
    dones = 0;
    res   = '0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge CLK);
      if (done) begin
        dones++;
        res = result;
      end
      if (dones != 0 && !busy) break;
    end
    repeat (40) begin
      @(negedge CLK);
      if (done) dones++;
    end
    check("busy_start_result", res,   17);
    check("busy_start_dones",  dones, 1);
    check("busy_start_idle",   busy,  0);

    // reset in the middle of a SUB step aborts the search
    wait_idle();
    start = 1'b1;
    n     = 16'd30030;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (50) @(negedge CLK);
    k = 0;
    while (dut.state != ST_SUB && k < 1000) begin
      @(negedge CLK);
      k++;
    end
    check("rst_mid_in_sub", (dut.state == ST_SUB), 1);
    RST_N = 1'b0;
    #1;
    check("rst_mid_busy",   busy,          0);
    check("rst_mid_done",   done,          0);
    check("rst_mid_error",  error,         0);
    check("rst_mid_result", result,        0);
    check("rst_mid_m",      dut.m,         0);
    check("rst_mid_nr",     dut.n_r,       0);
    check("rst_mid_a",      dut.u_gcd.a,   0);
    check("rst_mid_b",      dut.u_gcd.b,   0);
    dones = 0;
    repeat (3) begin
      @(negedge CLK);
      if (done) dones++;
    end
    RST_N = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      if (done) dones++;
    end
    check("rst_mid_no_done", dones, 0);
    check("rst_mid_idle",    busy,  0);
    do_case("after_rst_n6", 16'd6, 1'b1);

    // random operands against the arithmetic model
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] rn;
      rn = W'($urandom_range(1, 255));
      do_case("rand", rn, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_relprime_controller
